// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host scancode receiver.
// Synchronises and deglitches the raw PS/2 pins, deserialises 11-bit frames
// (start, 8 data LSB-first, odd parity, stop), folds E0/F0 prefixes into
// flags and emits one strobe per key event or per bad frame.
//
// Output handshake: code_valid and frame_err are single-cycle strobes with no
// backpressure. While code_valid is high, scancode/extended/released carry the
// event. Those three hold their value until the next code_valid. The two
// strobes are mutually exclusive.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       code_valid,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2} state_t;

  state_t state_q, state_d;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic clk_f_q, clk_f_d, dat_f_q, dat_f_d, clk_fd_q;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;

  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [10:0]   shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    scancode_q, scancode_d;
  logic          extended_q, extended_d, released_q, released_d;
  logic          code_valid_q, code_valid_d, frame_err_q, frame_err_d;

  logic sample, timeout, frame_ok;

  // A filtered clock fall is the only event that moves a bit into the frame.
  assign sample   = clk_fd_q & ~clk_f_q;
  assign timeout  = (state_q == RECV) && !sample && (tmo_q == TMO_MAX);
  assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & shift_q[10];

  // Filter next state: level flips after FILTER_LEN consecutive opposite samples.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    clk_f_d   = clk_f_q;
    dat_cnt_d = dat_cnt_q;
    dat_f_d   = dat_f_q;
    if (clk_s2_q == clk_f_q) begin
      clk_cnt_d = '0;
    end else if (clk_cnt_q == FILT_MAX) begin
      clk_f_d   = clk_s2_q;
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
    if (dat_s2_q == dat_f_q) begin
      dat_cnt_d = '0;
    end else if (dat_cnt_q == FILT_MAX) begin
      dat_f_d   = dat_s2_q;
      dat_cnt_d = '0;
    end else begin
      dat_cnt_d = dat_cnt_q + 1'b1;
    end
  end

  // Input path registers: synchronisers and filters, idle-high after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      clk_f_q   <= 1'b1;
      dat_f_q   <= 1'b1;
      clk_fd_q  <= 1'b1;
      clk_cnt_q <= '0;
      dat_cnt_q <= '0;
    end else begin
      clk_s1_q  <= clkps2;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= dataps2;
      dat_s2_q  <= dat_s1_q;
      clk_f_q   <= clk_f_d;
      dat_f_q   <= dat_f_d;
      clk_fd_q  <= clk_f_q;
      clk_cnt_q <= clk_cnt_d;
      dat_cnt_q <= dat_cnt_d;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frame next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample && !dat_f_q) state_d = RECV;
      RECV: begin
        if (timeout)                          state_d = IDLE;
        else if (sample && bitcnt_q == 4'd10) state_d = CHECK;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: bit capture, timeout, prefix folding and strobes.
  always_comb begin
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    tmo_d        = (sample || state_q != RECV) ? '0 : tmo_q + 1'b1;
    ext_d        = ext_q;
    brk_d        = brk_q;
    scancode_d   = scancode_q;
    extended_d   = extended_q;
    released_d   = released_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample && !dat_f_q) begin
          shift_d[0] = 1'b0;
          bitcnt_d   = 4'd1;
        end
      end
      RECV: begin
        if (timeout) begin
          bitcnt_d    = 4'd0;
          frame_err_d = 1'b1;
        end else if (sample) begin
          shift_d[bitcnt_q] = dat_f_q;
          bitcnt_d          = bitcnt_q + 4'd1;
        end
      end
      CHECK: begin
        bitcnt_d = 4'd0;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end else if (shift_q[8:1] == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shift_q[8:1] == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          scancode_d   = shift_q[8:1];
          extended_d   = ext_q;
          released_d   = brk_q;
          code_valid_d = 1'b1;
          ext_d        = 1'b0;
          brk_d        = 1'b0;
        end
      end
      default: bitcnt_d = 4'd0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bitcnt_q     <= 4'd0;
      shift_q      <= '0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      scancode_q   <= 8'h00;
      extended_q   <= 1'b0;
      released_q   <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      scancode_q   <= scancode_d;
      extended_q   <= extended_d;
      released_q   <= released_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scancode   = scancode_q;
  assign extended   = extended_q;
  assign released   = released_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: drives PS/2 frames, predicts key events with
// a byte-level model and checks every strobe from a monitor process.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       clkps2;
  logic       dataps2;
  logic [7:0] scancode;
  logic       extended, released, code_valid, frame_err;
  logic [1:0] dbg_state;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  longint last_fall_cyc = 0;

  // Expected event: {is_timeout, is_err, extended, released, scancode[7:0]}
  logic [11:0] exp_q[$];

  // Model state (byte-level view of the protocol)
  logic       m_ext, m_brk;
  logic [7:0] m_code;
  logic       m_oext, m_orel;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(6500)) dut (
    .clk(clk), .reset(reset), .clkps2(clkps2), .dataps2(dataps2),
    .scancode(scancode), .extended(extended), .released(released),
    .code_valid(code_valid), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #77 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(154 * 80000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_code = 8'h00; m_oext = 0; m_orel = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back({1'b0, 1'b1, m_oext, m_orel, m_code});
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      m_code = b; m_oext = m_ext; m_orel = m_brk;
      exp_q.push_back({1'b0, 1'b0, m_oext, m_orel, m_code});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_timeout();
    exp_q.push_back({1'b1, 1'b1, m_oext, m_orel, m_code});
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input int half, input bit glitch);
    dataps2 = b;
    if (glitch) begin
      wait_cyc(5);
      clkps2 = 1'b0;
      wait_cyc(3);
      clkps2 = 1'b1;
      wait_cyc(half - 8);
    end else begin
      wait_cyc(half);
    end
    clkps2 = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(half);
    clkps2 = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int half, input bit bad_par,
                           input bit bad_stop, input bit glitch, input int nbits);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
    bits[9]    = (~^b) ^ bad_par;
    bits[10]   = ~bad_stop;
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], half, glitch);
    dataps2 = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_event(input logic [7:0] b, input int half, input bit bad_par,
                            input bit bad_stop, input bit glitch);
    model_frame(b, !(bad_par || bad_stop));
    send_bits(b, half, bad_par, bad_stop, glitch, 11);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b1 && (code_valid || frame_err)) begin
      check("strobe_exclusive", {31'd0, code_valid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got code_valid=%0b frame_err=%0b scancode=%0h expected none",
                 code_valid, frame_err, scancode);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("strobe_kind_err", {31'd0, frame_err}, {31'd0, e[10]});
        check("scancode", {24'd0, scancode}, {24'd0, e[7:0]});
        check("extended", {31'd0, extended}, {31'd0, e[9]});
        check("released", {31'd0, released}, {31'd0, e[8]});
        if (e[11]) check_range("timeout_latency", cyc - last_fall_cyc, 6505, 6515);
        else       check_range("frame_latency", cyc - last_fall_cyc, 11, 13);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; clkps2 = 1'b1; dataps2 = 1'b1;
    model_reset();
    wait_cyc(5);
    check("rst_scancode", {24'd0, scancode}, 32'h0);
    check("rst_extended", {31'd0, extended}, 32'd0);
    check("rst_released", {31'd0, released}, 32'd0);
    check("rst_code_valid", {31'd0, code_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    wait_cyc(20);

    // A make at 12.5 kHz (260 system clocks per half period)
    send_event(8'h1C, 260, 0, 0, 0);
    // break, then plain make
    send_event(8'hF0, 40, 0, 0, 0);
    send_event(8'h1C, 40, 0, 0, 0);
    send_event(8'h1C, 40, 0, 0, 0);
    // extended break
    send_event(8'hE0, 40, 0, 0, 0);
    send_event(8'hF0, 40, 0, 0, 0);
    send_event(8'h75, 40, 0, 0, 0);
    // parity error, then recovery
    send_event(8'h1C, 40, 1, 0, 0);
    send_event(8'h29, 40, 0, 0, 0);
    // mid-frame timeout, then recovery
    model_timeout();
    send_bits(8'h5A, 40, 0, 0, 0, 5);
    wait_cyc(7000);
    send_event(8'h5A, 40, 0, 0, 0);
    // short clock glitches between bits
    send_event(8'h1C, 40, 0, 0, 1);
    // reset mid-frame discards the partial frame
    send_bits(8'h1C, 40, 0, 0, 0, 5);
    reset = 1'b0;
    wait_cyc(1);
    check("midrst_scancode", {24'd0, scancode}, 32'h0);
    check("midrst_code_valid", {31'd0, code_valid}, 32'd0);
    reset = 1'b1;
    model_reset();
    wait_cyc(20);
    send_event(8'h1C, 40, 0, 0, 0);

    // randomized traffic, biased toward prefixes and occasional errors
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      int sel, half, err;
      sel  = $urandom_range(0, 5);
      b    = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      half = $urandom_range(16, 40);
      err  = $urandom_range(0, 7);
      send_event(b, half, err == 0, err == 1, (half >= 16) && ($urandom_range(0, 3) == 0));
    end

    wait_cyc(100);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
